// File: rtl/parc_imem_prefetch_queue_pkg.sv
// rtl/parc_imem_prefetch_queue_pkg.sv - shared constants, types and helpers for the prefetch queue
package parc_imem_prefetch_queue_pkg;

  // Default fetch address after reset
  localparam logic [31:0] PF_DEFAULT_RESET_PC = 32'h0000_1000;

  // Sequential fetch stride in bytes
  localparam int PF_PC_STEP = 4;

  // Fetch is held off for the first cycle after reset is released
  typedef enum logic {
    PF_ST_HALT = 1'b0,
    PF_ST_RUN  = 1'b1
  } pf_state_e;

  // Width of a counter that must hold values 0..depth
  function automatic int pf_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/parc_imem_prefetch_queue_if.sv
// rtl/parc_imem_prefetch_queue_if.sv - imem request/response, redirect and instruction handshakes
interface parc_imem_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imemreq_msg_addr;
  logic              imemreq_val;
  logic              imemreq_rdy;
  logic [DATA_W-1:0] imemresp_msg_data;
  logic              imemresp_val;
  logic              redirect_val;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_val;
  logic              inst_rdy;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  // Fetch unit side
  modport master (
    output imemreq_msg_addr, imemreq_val,
    input  imemreq_rdy,
    input  imemresp_msg_data, imemresp_val,
    input  redirect_val, redirect_pc,
    output inst_val, inst_data, inst_pc,
    input  inst_rdy
  );

  // Memory and core side
  modport slave (
    input  imemreq_msg_addr, imemreq_val,
    output imemreq_rdy,
    output imemresp_msg_data, imemresp_val,
    output redirect_val, redirect_pc,
    input  inst_val, inst_data, inst_pc,
    output inst_rdy
  );
endinterface

// File: rtl/parc_imem_prefetch_queue_ring.sv
// rtl/parc_imem_prefetch_queue_ring.sv - circular buffer of {pc, instruction} entries
module parc_imem_prefetch_queue_ring #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_enq,
  input  logic [ADDR_W-1:0] i_enq_pc,
  input  logic [DATA_W-1:0] i_enq_data,
  input  logic              i_deq,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] o_head_pc,
  output logic [DATA_W-1:0] o_head_data
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;

  // Pointer update; power-of-two depth lets the pointers wrap by overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Entry storage; a write landing in a flush cycle belongs to the old path and is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (i_enq && !i_flush) begin
      r_pc[r_wr_ptr]   <= i_enq_pc;
      r_data[r_wr_ptr] <= i_enq_data;
    end
  end

  assign o_head_pc   = r_pc[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
endmodule

// File: rtl/parc_imem_prefetch_queue.sv
// rtl/parc_imem_prefetch_queue.sv - sequential instruction prefetcher with redirect flush
module parc_imem_prefetch_queue
  import parc_imem_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PF_DEFAULT_RESET_PC)
) (
  input logic                         clk,
  input logic                         reset,
  parc_imem_prefetch_queue_if.master  bus
);
  localparam int CW = pf_cnt_w(DEPTH);
  // drop can exceed DEPTH: new-path requests issue while old-path responses drain
  localparam int DW = CW + 1;

  pf_state_e         r_state;
  pf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_inflight;
  logic [DW-1:0]     r_drop;

  logic [CW:0]       w_credit_used;
  logic              w_req_val;
  logic              w_fire;
  logic              w_resp_drop;
  logic              w_resp_take;
  logic              w_resp_legal;
  logic              w_enq;
  logic              w_inst_val;
  logic              w_deq;

  // Issue credit counts only registered occupancy, never a same-cycle dequeue
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_req_val     = (r_state == PF_ST_RUN) && !bus.redirect_val &&
                         (w_credit_used < (CW+1)'(DEPTH));
  assign w_fire        = w_req_val && bus.imemreq_rdy;
  assign w_resp_drop   = bus.imemresp_val && (r_drop != '0);
  assign w_resp_take   = bus.imemresp_val && (r_drop == '0) && (r_inflight != '0);
  assign w_resp_legal  = w_resp_drop || w_resp_take;
  assign w_enq         = w_resp_take && !bus.redirect_val;
  assign w_inst_val    = (r_count != '0);
  assign w_deq         = w_inst_val && bus.inst_rdy;

  // Run state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= PF_ST_HALT;
    else       r_state <= w_state_nxt;
  end

  // Leave the halt state on the first edge after reset release
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == PF_ST_HALT) w_state_nxt = PF_ST_RUN;
  end

  // Occupancy, in-flight and stale-response counters; redirect overrides everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (bus.redirect_val) begin
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= r_drop + DW'(r_inflight) - DW'(w_resp_legal);
    end else begin
      r_count    <= r_count + CW'(w_enq) - CW'(w_deq);
      r_inflight <= r_inflight + CW'(w_fire) - CW'(w_resp_take);
      r_drop     <= r_drop - DW'(w_resp_drop);
    end
  end

  // Request and response PC tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else if (bus.redirect_val) begin
      r_fetch_pc <= bus.redirect_pc;
      r_resp_pc  <= bus.redirect_pc;
    end else begin
      if (w_fire)      r_fetch_pc <= r_fetch_pc + ADDR_W'(PF_PC_STEP);
      if (w_resp_take) r_resp_pc  <= r_resp_pc + ADDR_W'(PF_PC_STEP);
    end
  end

  // Flag a response that matches no outstanding request
  always @(posedge clk) begin
    if (!reset && bus.imemresp_val)
      assert (r_inflight != '0 || r_drop != '0)
        else $error("parc_imem_prefetch_queue: response with nothing outstanding ignored");
  end

  parc_imem_prefetch_queue_ring #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .i_enq       (w_enq),
    .i_enq_pc    (r_resp_pc),
    .i_enq_data  (bus.imemresp_msg_data),
    .i_deq       (w_deq),
    .i_flush     (bus.redirect_val),
    .o_head_pc   (bus.inst_pc),
    .o_head_data (bus.inst_data)
  );

  assign bus.imemreq_msg_addr = r_fetch_pc;
  assign bus.imemreq_val      = w_req_val;
  assign bus.inst_val         = w_inst_val;
endmodule

// File: tb/tb_parc_imem_prefetch_queue.sv
// tb/tb_parc_imem_prefetch_queue.sv - randomized bench against a queue-level fetch model
module tb_parc_imem_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parc_imem_prefetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  parc_imem_prefetch_queue #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  mem_t        mem_q[$];
  ent_t        buf_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_run;
  int          cyc;
  int          dut_fires;
  int          p_rdy, p_inst_rdy, p_redir, lat_min, lat_max;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int live_out();
    int n = 0;
    foreach (mem_q[i]) if (!mem_q[i].stale) n++;
    return n;
  endfunction

  task automatic drive_idle();
    bus.imemreq_rdy       = 1'b0;
    bus.inst_rdy          = 1'b0;
    bus.redirect_val      = 1'b0;
    bus.redirect_pc       = '0;
    bus.imemresp_val      = 1'b0;
    bus.imemresp_msg_data = '0;
  endtask

  task automatic model_reset();
    mem_q.delete();
    buf_q.delete();
    m_fetch_pc = RESET_PC;
    m_run      = 1'b0;
  endtask

  // One clock: drive at negedge, check against the model, advance the model at posedge
  task automatic run_cycle();
    bit          resp, redir, exp_req, exp_inst, fire, deq;
    logic [31:0] rpc;
    mem_t        head;
    @(negedge clk);
    bus.imemreq_rdy = ($urandom_range(99) < p_rdy);
    bus.inst_rdy    = ($urandom_range(99) < p_inst_rdy);
    redir           = ($urandom_range(999) < p_redir);
    case ($urandom_range(3))
      0:       rpc = 32'h0000_2000;
      1:       rpc = 32'hFFFF_FFF8;
      default: rpc = $urandom & 32'hFFFF_FFFC;
    endcase
    bus.redirect_val      = redir;
    bus.redirect_pc       = rpc;
    resp                  = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    bus.imemresp_val      = resp;
    bus.imemresp_msg_data = resp ? memf(mem_q[0].addr) : $urandom;
    #1;
    exp_req  = m_run && !redir && ((buf_q.size() + live_out()) < DEPTH);
    exp_inst = (buf_q.size() != 0);
    check_eq("req_val", 64'(bus.imemreq_val), 64'(exp_req));
    check_eq("req_addr", 64'(bus.imemreq_msg_addr), 64'(m_fetch_pc));
    check_eq("inst_val", 64'(bus.inst_val), 64'(exp_inst));
    if (exp_inst) begin
      check_eq("inst_pc", 64'(bus.inst_pc), 64'(buf_q[0].pc));
      check_eq("inst_data", 64'(bus.inst_data), 64'(buf_q[0].data));
    end
    if (bus.imemreq_val && bus.imemreq_rdy) dut_fires++;
    fire = exp_req && bus.imemreq_rdy;
    deq  = exp_inst && bus.inst_rdy;
    @(posedge clk);
    if (deq) void'(buf_q.pop_front());
    if (resp) begin
      head = mem_q.pop_front();
      if (!head.stale && !redir) buf_q.push_back('{pc: head.addr, data: memf(head.addr)});
    end
    if (fire) begin
      mem_q.push_back('{addr: m_fetch_pc, due: cyc + $urandom_range(lat_max, lat_min), stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redir) begin
      buf_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      m_fetch_pc = rpc;
    end
    m_run = 1'b1;
    cyc++;
  endtask

  // Assert reset between edges and check the outputs clear without waiting for a clock
  task automatic mid_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_req_val", 64'(bus.imemreq_val), 64'd0);
    check_eq("rst_inst_val", 64'(bus.inst_val), 64'd0);
    check_eq("rst_req_addr", 64'(bus.imemreq_msg_addr), 64'(RESET_PC));
    check_eq("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
    check_eq("rst_inst_data", 64'(bus.inst_data), 64'd0);
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    cyc       = 0;
    dut_fires = 0;
    reset     = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("init_req_val", 64'(bus.imemreq_val), 64'd0);
    check_eq("init_inst_val", 64'(bus.inst_val), 64'd0);
    check_eq("init_req_addr", 64'(bus.imemreq_msg_addr), 64'(RESET_PC));
    check_eq("init_inst_pc", 64'(bus.inst_pc), 64'd0);
    reset = 1'b0;

    // Streaming: memory always ready with single-cycle latency, core always consuming
    p_rdy = 100; p_inst_rdy = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    repeat (60) run_cycle();

    // Core stalled from reset: exactly DEPTH requests, then drain in order
    mid_reset();
    p_inst_rdy = 0;
    dut_fires  = 0;
    repeat (20) run_cycle();
    check_eq("stall_req_cnt", 64'(dut_fires), 64'(DEPTH));
    check_eq("stall_head_pc", 64'(bus.inst_pc), 64'(RESET_PC));
    check_eq("stall_next_addr", 64'(bus.imemreq_msg_addr), 64'(RESET_PC + 32'h10));
    p_inst_rdy = 100;
    repeat (20) run_cycle();

    // Random traffic with redirects, backpressure and variable latency
    p_rdy = 70; p_inst_rdy = 60; p_redir = 40; lat_min = 1; lat_max = 4;
    repeat (3000) run_cycle();

    // Reset in the middle of busy traffic, then restart with long latency
    mid_reset();
    p_rdy = 80; p_inst_rdy = 80; p_redir = 60; lat_min = 3; lat_max = 3;
    repeat (400) run_cycle();

    // Heavy redirect rate with slow memory
    p_rdy = 50; p_inst_rdy = 50; p_redir = 200; lat_min = 1; lat_max = 5;
    repeat (600) run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
